mic1_out_uart_tx: RTL

MIC1_OUT_UART_TX -- requirements
Module: mic1_out_uart_tx

---
 rtl/mic1_uart_pkg.sv | 28 ++
 rtl/uart_tx_byte.sv | 110 +++++++++++
 rtl/mic1_out_uart_tx.sv | 69 ++++++
 3 files changed

// File: rtl/mic1_uart_pkg.sv
// Shared types and helpers for the mic1 output-word UART reporter.
package mic1_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Character idx of a report line: 8 hex digits (MS nibble first), CR, LF.
  function automatic logic [7:0] frame_char(input logic [31:0] word, input logic [3:0] idx);
    case (idx)
      4'd8:    return ASCII_CR;
      4'd9:    return ASCII_LF;
      default: return nib2ascii(word[{~idx[2:0], 2'b00} +: 4]);
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for one byte. A start strobe in IDLE, or on the final
// cycle of a stop bit, loads the next byte so characters run back-to-back.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_IDLE  | line idle high, waiting for i_start
//   ST_START | driving start bit (0)
//   ST_DATA  | driving data bit r_bit, LSB first
//   ST_STOP  | driving stop bit (1); o_done on its last cycle
module uart_tx_byte
  import mic1_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 52
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] i_byte,
  input  logic       i_start,
  output logic       o_tx,
  output logic       o_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_e   r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_byte, w_byte_nxt;
  logic          r_tx, w_tx_nxt;
  logic          w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign o_done    = (r_state == ST_STOP) && w_bit_end;
  assign o_tx      = r_tx;

  // State, counters and the registered line output.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next-state: advance one bit every CLKS_PER_BIT cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_tx_nxt    = r_tx;
    if (r_state != ST_IDLE) begin
      w_baud_nxt = w_bit_end ? '0 : r_baud + BW'(1);
    end
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_START;
          w_byte_nxt  = i_byte;
          w_baud_nxt  = '0;
          w_tx_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = r_byte[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt  = r_byte[w_bit_nxt];
          end
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (i_start) begin
            w_state_nxt = ST_START;
            w_byte_nxt  = i_byte;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mic1_out_uart_tx.sv
// Reports a mic1 output word as an ASCII hex line "XXXXXXXX\r\n" over UART.
// r_char_idx is the character currently on the line; the next character is
// handed to the serializer on the cycle its predecessor's stop bit ends.
module mic1_out_uart_tx
  import mic1_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 52
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] word_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        tx_o,
  output logic        busy_o
);

  logic        r_busy;
  logic [3:0]  r_char_idx;
  logic [31:0] r_word;

  logic        w_accept;
  logic        w_last_char;
  logic        w_start;
  logic        w_done;
  logic [7:0]  w_byte;

  assign w_accept    = valid_i && !r_busy;
  assign w_last_char = (r_char_idx == 4'd9);
  assign w_start     = w_accept || (w_done && !w_last_char);
  // First character comes straight from word_i: r_word is loaded on the same edge.
  assign w_byte      = w_accept ? frame_char(word_i, 4'd0)
                                : frame_char(r_word, r_char_idx + 4'd1);

  assign ready_o = !r_busy;
  assign busy_o  = r_busy;

  // Frame sequencing: capture on handshake, step through the 10 characters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_busy     <= 1'b0;
      r_char_idx <= '0;
      r_word     <= '0;
    end else if (w_accept) begin
      r_busy     <= 1'b1;
      r_char_idx <= '0;
      r_word     <= word_i;
    end else if (w_done) begin
      if (w_last_char) begin
        r_busy     <= 1'b0;
        r_char_idx <= '0;
      end else begin
        r_char_idx <= r_char_idx + 4'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk     (clk),
    .resetn  (resetn),
    .i_byte  (w_byte),
    .i_start (w_start),
    .o_tx    (tx_o),
    .o_done  (w_done)
  );

endmodule
